// File: rtl/gray_updn_cnt.sv
// Up/down Gray-code counter with enable, parallel load, optional saturation and a
// registered terminal-count pulse; binary and Gray views are both registered.
module gray_updn_cnt #(
    parameter int N        = 4,
    parameter int SATURATE = 0,
    parameter int RST_VAL  = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic         ld,
    input  logic [N-1:0] ld_val,
    output logic [N-1:0] gray,
    output logic [N-1:0] bin,
    output logic         tc
);

    localparam logic [N-1:0] RST_BIN  = N'(RST_VAL);
    localparam logic [N-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
    localparam logic [N-1:0] MAX_VAL  = {N{1'b1}};

    logic [N-1:0] b_reg;
    logic [N-1:0] b_next;
    logic [N-1:0] gray_reg;
    logic [N-1:0] gray_next;
    logic         tc_reg;
    logic         tc_next;
    logic         at_limit;

    always_comb begin
        b_next   = b_reg;
        tc_next  = 1'b0;
        at_limit = up ? (b_reg == MAX_VAL) : (b_reg == '0);
        if (ld) begin
            b_next = ld_val;
        end else if (en) begin
            if (at_limit) begin
                // Terminal step: pulse tc, then either wrap or hold at the limit
                tc_next = 1'b1;
                if (SATURATE == 0)
                    b_next = up ? '0 : MAX_VAL;
            end else begin
                b_next = up ? (b_reg + N'(1)) : (b_reg - N'(1));
            end
        end
    end

    // Gray view is derived from the next binary value so both registers agree on every edge
    generate
        for (genvar gi = 0; gi < N - 1; gi++) begin : g_gray
            assign gray_next[gi] = b_next[gi] ^ b_next[gi+1];
        end
    endgenerate
    assign gray_next[N-1] = b_next[N-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            b_reg    <= RST_BIN;
            gray_reg <= RST_GRAY;
            tc_reg   <= 1'b0;
        end else begin
            b_reg    <= b_next;
            gray_reg <= gray_next;
            tc_reg   <= tc_next;
        end
    end

    assign bin  = b_reg;
    assign gray = gray_reg;
    assign tc   = tc_reg;

endmodule
